// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
//   state_e   : supervisor FSM states
//   LossCntW  : width of the saturating lock-loss counter
//   cnt_width : bits needed to count 0..n-1 (never less than 1)
//   max3      : largest of three cycle parameters, sizes the shared timer
package pll_sup_pkg;

  typedef enum logic [2:0] {
    StAssertRst,
    StWaitLock,
    StStable,
    StRun,
    StFault
  } state_e;

  localparam int unsigned LossCntW = 8;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single level signal crossing into clk_i.
//   clk_i : destination clock
//   rst_i : synchronous active-high reset, clears both stages to 0
//   d_i   : asynchronous level input
//   q_o   : synchronized level
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: drives the PLL reset pin, waits for a stable lock and only then
// releases the system reset. Retries on lock timeout, re-sequences on lock loss and parks
// in a sticky fault after too many failed attempts.
//   clk          : reference clock (also the PLL input clock)
//   reset        : synchronous active-high block reset
//   lock_i       : PLL lock, asynchronous to clk
//   clear_i      : leave FAULT and restart (ignored elsewhere)
//   pll_reset_o  : PLL reset, high in ASSERT_RST and FAULT
//   sys_reset_o  : system reset, low only in RUN
//   ready_o      : high in RUN
//   fault_o      : high in FAULT
//   retry_cnt_o  : failed attempts in the current sequence
//   loss_cnt_o   : lock-loss events seen in RUN, saturating
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT = 50000,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned MAX_RETRY    = 3,
  localparam int unsigned RetryW      = cnt_width(MAX_RETRY + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                lock_i,
  input  logic                clear_i,
  output logic                pll_reset_o,
  output logic                sys_reset_o,
  output logic                ready_o,
  output logic                fault_o,
  output logic [RetryW-1:0]   retry_cnt_o,
  output logic [LossCntW-1:0] loss_cnt_o
);

  localparam int unsigned TimerW = cnt_width(max3(RESET_CYCLES, LOCK_TIMEOUT, LOCK_STABLE));

  localparam logic [TimerW-1:0] RstLast     = TimerW'(RESET_CYCLES - 1);
  localparam logic [TimerW-1:0] TimeoutLast = TimerW'(LOCK_TIMEOUT - 1);
  localparam logic [TimerW-1:0] StableLast  = TimerW'(LOCK_STABLE - 1);
  localparam logic [RetryW-1:0] RetryMax    = RetryW'(MAX_RETRY);

  logic lock_s;

  sync_2ff u_lock_sync (
    .clk_i (clk),
    .rst_i (reset),
    .d_i   (lock_i),
    .q_o   (lock_s)
  );

  state_e              state_q, state_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [RetryW-1:0]   retry_q, retry_d;
  logic [LossCntW-1:0] loss_q, loss_d;
  logic                pll_reset_q, pll_reset_d;
  logic                sys_reset_q, sys_reset_d;
  logic                ready_q, ready_d;
  logic                fault_q, fault_d;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q + TimerW'(1);
    retry_d = retry_q;
    loss_d  = loss_q;

    unique case (state_q)
      StAssertRst: begin
        if (timer_q == RstLast) state_d = StWaitLock;
      end
      StWaitLock: begin
        // Lock takes priority over a timeout landing on the same cycle.
        if (lock_s) begin
          state_d = StStable;
        end else if (timer_q == TimeoutLast) begin
          if (retry_q == RetryMax) begin
            state_d = StFault;
          end else begin
            retry_d = retry_q + RetryW'(1);
            state_d = StAssertRst;
          end
        end
      end
      StStable: begin
        if (!lock_s) begin
          state_d = StWaitLock;
        end else if (timer_q == StableLast) begin
          state_d = StRun;
        end
      end
      StRun: begin
        timer_d = timer_q;
        if (!lock_s) begin
          state_d = StAssertRst;
          retry_d = '0;
          if (loss_q != '1) loss_d = loss_q + LossCntW'(1);
        end
      end
      StFault: begin
        timer_d = timer_q;
        if (clear_i) begin
          state_d = StAssertRst;
          retry_d = '0;
        end
      end
      default: state_d = StAssertRst;
    endcase

    if (state_d != state_q) timer_d = '0;

    // Outputs decode the next state so they change on the same edge as the state.
    pll_reset_d = (state_d == StAssertRst) || (state_d == StFault);
    sys_reset_d = (state_d != StRun);
    ready_d     = (state_d == StRun);
    fault_d     = (state_d == StFault);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StAssertRst;
      timer_q     <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      pll_reset_q <= 1'b1;
      sys_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      pll_reset_q <= pll_reset_d;
      sys_reset_q <= sys_reset_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
    end
  end

  assign pll_reset_o = pll_reset_q;
  assign sys_reset_o = sys_reset_q;
  assign ready_o     = ready_q;
  assign fault_o     = fault_q;
  assign retry_cnt_o = retry_q;
  assign loss_cnt_o  = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with RESET_CYCLES=4, LOCK_TIMEOUT=20,
// LOCK_STABLE=8, MAX_RETRY=2. Each table row holds inputs for n cycles and the outputs
// expected after every one of those edges.
module tb_pll_lock_supervisor;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       lock_i = 1'b0;
  logic       clear_i = 1'b0;
  logic       pll_reset_o, sys_reset_o, ready_o, fault_o;
  logic [1:0] retry_cnt_o;
  logic [7:0] loss_cnt_o;

  int tests = 0;
  int fails = 0;

  pll_lock_supervisor #(
    .RESET_CYCLES (4),
    .LOCK_TIMEOUT (20),
    .LOCK_STABLE  (8),
    .MAX_RETRY    (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .lock_i      (lock_i),
    .clear_i     (clear_i),
    .pll_reset_o (pll_reset_o),
    .sys_reset_o (sys_reset_o),
    .ready_o     (ready_o),
    .fault_o     (fault_o),
    .retry_cnt_o (retry_cnt_o),
    .loss_cnt_o  (loss_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic       lock;
    logic       clr;
    int         n;
    logic       pll;
    logic       sys;
    logic       rdy;
    logic       flt;
    logic [1:0] retry;
    logic [7:0] loss;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input string name, input logic rst, input logic lock,
                              input logic clr, input int n, input logic pll, input logic sys,
                              input logic rdy, input logic flt, input logic [1:0] retry,
                              input logic [7:0] loss);
    vec_t v;
    v.name = name; v.rst = rst; v.lock = lock; v.clr = clr; v.n = n;
    v.pll = pll; v.sys = sys; v.rdy = rdy; v.flt = flt; v.retry = retry; v.loss = loss;
    tbl.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic pll, input logic sys,
                       input logic rdy, input logic flt, input logic [1:0] retry,
                       input logic [7:0] loss);
    tests++;
    if ({pll_reset_o, sys_reset_o, ready_o, fault_o, retry_cnt_o, loss_cnt_o} !==
        {pll, sys, rdy, flt, retry, loss}) begin
      fails++;
      $display("FAIL %s[%0d]: got pll=%b sys=%b rdy=%b flt=%b retry=%0d loss=%0d, want pll=%b sys=%b rdy=%b flt=%b retry=%0d loss=%0d",
               name, idx, pll_reset_o, sys_reset_o, ready_o, fault_o, retry_cnt_o,
               loss_cnt_o, pll, sys, rdy, flt, retry, loss);
    end
  endtask

  // Bounded wait for RUN; an expired budget counts as a failed comparison.
  task automatic wait_ready(input string name, input int budget);
    int k;
    k = 0;
    while (!ready_o && k < budget) begin
      tick();
      k++;
    end
    tests++;
    if (!ready_o) begin
      fails++;
      $display("FAIL %s: ready_o=%b after %0d cycles, want 1", name, ready_o, budget);
    end
  endtask

  initial begin
    //  name        rst lk clr  n  pll sys rdy flt retry loss
    // Nominal bring-up, lock raised 10 cycles after reset release.
    add("rst_vals",  1, 0, 0,  2, 1, 1, 0, 0, 0, 0);
    add("assert_rst",0, 0, 0,  3, 1, 1, 0, 0, 0, 0);
    add("wait_lock", 0, 0, 0,  7, 0, 1, 0, 0, 0, 0);
    add("acquire",   0, 1, 0, 10, 0, 1, 0, 0, 0, 0);
    add("run",       0, 1, 0,  3, 0, 0, 1, 0, 0, 0);
    // Two-cycle lock drop: seen three edges after the fall.
    add("loss_sync", 0, 0, 0,  2, 0, 0, 1, 0, 0, 0);
    add("loss_rst",  0, 1, 0,  4, 1, 1, 0, 0, 0, 1);
    add("loss_wait", 0, 1, 0,  1, 0, 1, 0, 0, 0, 1);
    add("loss_stab", 0, 1, 0,  8, 0, 1, 0, 0, 0, 1);
    add("loss_run",  0, 1, 0,  2, 0, 0, 1, 0, 0, 1);
    // Reset from RUN clears the loss counter; then a stable-window abort.
    add("rst_run",   1, 1, 0,  1, 1, 1, 0, 0, 0, 0);
    add("ab_arst",   0, 0, 0,  3, 1, 1, 0, 0, 0, 0);
    add("ab_wait",   0, 0, 0,  1, 0, 1, 0, 0, 0, 0);
    add("ab_hi5",    0, 1, 0,  5, 0, 1, 0, 0, 0, 0);
    add("ab_lo3",    0, 0, 0,  3, 0, 1, 0, 0, 0, 0);
    add("ab_rehi",   0, 1, 0, 10, 0, 1, 0, 0, 0, 0);
    add("ab_run",    0, 1, 0,  1, 0, 0, 1, 0, 0, 0);
    // Lock never arrives: three attempts then FAULT; clear ignored outside FAULT.
    add("rf_rst",    1, 0, 0,  1, 1, 1, 0, 0, 0, 0);
    add("rf_pulse0", 0, 0, 0,  3, 1, 1, 0, 0, 0, 0);
    add("rf_wait0",  0, 0, 0, 20, 0, 1, 0, 0, 0, 0);
    add("rf_pulse1", 0, 0, 0,  4, 1, 1, 0, 0, 1, 0);
    add("rf_wait1",  0, 0, 1, 20, 0, 1, 0, 0, 1, 0);
    add("rf_pulse2", 0, 0, 0,  4, 1, 1, 0, 0, 2, 0);
    add("rf_wait2",  0, 0, 0, 20, 0, 1, 0, 0, 2, 0);
    add("rf_fault",  0, 0, 0,  3, 1, 1, 0, 1, 2, 0);
    add("rf_clear",  0, 0, 1,  1, 1, 1, 0, 0, 0, 0);
    add("rf_arst",   0, 0, 0,  3, 1, 1, 0, 0, 0, 0);
    add("rf_wait",   0, 0, 0,  1, 0, 1, 0, 0, 0, 0);
    // lock_s rises on the timeout cycle: lock must win, then reset inside STABLE.
    add("sim_lo",    0, 0, 0, 17, 0, 1, 0, 0, 0, 0);
    add("sim_hi",    0, 1, 0,  2, 0, 1, 0, 0, 0, 0);
    add("sim_stab",  0, 1, 0,  1, 0, 1, 0, 0, 0, 0);
    add("sim_stab2", 0, 1, 0,  3, 0, 1, 0, 0, 0, 0);
    add("sim_rst",   1, 1, 0,  1, 1, 1, 0, 0, 0, 0);

    foreach (tbl[r]) begin
      reset   = tbl[r].rst;
      lock_i  = tbl[r].lock;
      clear_i = tbl[r].clr;
      for (int j = 0; j < tbl[r].n; j++) begin
        tick();
        check(tbl[r].name, j, tbl[r].pll, tbl[r].sys, tbl[r].rdy, tbl[r].flt,
              tbl[r].retry, tbl[r].loss);
      end
    end

    // Repeated lock loss until the counter saturates.
    reset   = 1'b1;
    lock_i  = 1'b1;
    clear_i = 1'b0;
    tick();
    reset = 1'b0;
    wait_ready("sat_first_run", 40);
    for (int i = 1; i <= 260; i++) begin
      lock_i = 1'b0;
      tick();
      tick();
      lock_i = 1'b1;
      tick();
      check("sat_loss", i, 1, 1, 0, 0, 0, (i > 255) ? 8'd255 : 8'(i));
      wait_ready("sat_relock", 30);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
